// File: rtl/phv_deparser_pkg.sv
// phv_deparser_pkg: PHV container layout, parse-action word fields, deparser states and the header patch helper.
package phv_deparser_pkg;
  localparam int HDR_W = 1024;
  localparam int AXIS_DW = 256;
  localparam int SEG_NUM = HDR_W / AXIS_DW;
  localparam int PHV_W = 1124;
  localparam int ACT_NUM = 10;
  localparam int C6_BASE = 740;
  localparam int C4_BASE = 484;
  localparam int C2_BASE = 356;
  localparam int ACT_VLD = 0;
  localparam int ACT_IDX_LSB = 1;
  localparam int ACT_TYP_LSB = 4;
  localparam int ACT_OFF_LSB = 6;
  localparam logic [1:0] T_2B = 2'd1;
  localparam logic [1:0] T_4B = 2'd2;
  localparam logic [1:0] T_6B = 2'd3;

  typedef enum logic [2:0] {IDLE, HDR_RD, ACT, PATCH, EMIT_HDR, EMIT_BODY} state_t;

  function automatic logic [47:0] container(input logic [PHV_W-1:0] phv, input logic [1:0] typ,
                                            input logic [2:0] idx);
    return typ == T_6B ? phv[C6_BASE + 48*int'(idx) +: 48] :
           typ == T_4B ? {16'h0, phv[C4_BASE + 32*int'(idx) +: 32]} :
           typ == T_2B ? {32'h0, phv[C2_BASE + 16*int'(idx) +: 16]} : 48'h0;
  endfunction

  // A write that would run past the 1024-bit header is dropped whole, never truncated.
  function automatic logic [HDR_W-1:0] patch(input logic [HDR_W-1:0] hdr, input logic [PHV_W-1:0] phv,
                                             input logic [15:0] act);
    logic [1:0] typ;
    logic [47:0] c;
    int lo;
    typ = act[ACT_TYP_LSB +: 2];
    c = container(phv, typ, act[ACT_IDX_LSB +: 3]);
    lo = 8 * int'(act[ACT_OFF_LSB +: 7]);
    if (act[ACT_VLD])
      case (typ)
        T_2B: if (lo + 16 <= HDR_W) hdr[lo +: 16] = c[15:0];
        T_4B: if (lo + 32 <= HDR_W) hdr[lo +: 32] = c[31:0];
        T_6B: if (lo + 48 <= HDR_W) hdr[lo +: 48] = c;
        default: ;
      endcase
    return hdr;
  endfunction
endpackage

// File: rtl/axis_pkt_fifo.sv
// axis_pkt_fifo: synchronous first-word-fall-through FIFO holding whole AXIS beats.
module axis_pkt_fifo #(
  parameter int W     = 417,
  parameter int DEPTH = 64
) (
  input  logic         axis_clk,
  input  logic         aresetn,
  input  logic         wr_en_i,
  input  logic [W-1:0] din_i,
  input  logic         rd_en_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0] wr_q, rd_q;
  logic wr_ok, rd_ok;
  assign full_o = wr_q[AW] != rd_q[AW] && wr_q[AW-1:0] == rd_q[AW-1:0];
  assign empty_o = wr_q == rd_q;
  assign wr_ok = wr_en_i & !full_o;
  assign rd_ok = rd_en_i & !empty_o;
  assign dout_o = mem_q[rd_q[AW-1:0]];
  always_ff @(posedge axis_clk)
    if (wr_ok) mem_q[wr_q[AW-1:0]] <= din_i;
  always_ff @(posedge axis_clk or negedge aresetn) begin
    if (!aresetn) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (wr_ok) wr_q <= wr_q + 1'b1;
      if (rd_ok) rd_q <= rd_q + 1'b1;
    end
  end
endmodule

// File: rtl/phv_deparser.sv
// phv_deparser: buffers AXIS packets, writes PHV containers back into the first 1024 header bits, re-emits them.
module phv_deparser
  import phv_deparser_pkg::*;
#(
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int PKT_HDR_LEN          = 1124,
  parameter int FIFO_DEPTH           = 64
) (
  input  logic                              axis_clk,
  input  logic                              aresetn,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
  input  logic                              s_axis_tvalid,
  input  logic                              s_axis_tlast,
  output logic                              s_axis_tready,
  input  logic [PKT_HDR_LEN-1:0]            phv_in,
  input  logic                              phv_valid_in,
  output logic [3:0]                        act_addr,
  input  logic [ACT_NUM*16-1:0]             act_data,
  output logic [C_S_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
  output logic                              m_axis_tvalid,
  output logic                              m_axis_tlast,
  input  logic                              m_axis_tready,
  output logic                              phv_drop
);
  localparam int DW = C_S_AXIS_DATA_WIDTH;
  localparam int UW = C_S_AXIS_TUSER_WIDTH;
  localparam int KW = DW / 8;
  localparam int SIW = $clog2(SEG_NUM);
  localparam int FW = DW + UW + KW + 1;
  state_t state_q;
  logic [SIW-1:0] seg_q, last_seg_q;
  logic [HDR_W-1:0] hdr_q, hdr_patch;
  logic [SEG_NUM-1:0][KW-1:0] keep_q;
  logic [SEG_NUM-1:0][UW-1:0] user_q;
  logic [SEG_NUM-1:0] last_q;
  logic [PKT_HDR_LEN-1:0] phv_q;
  logic phv_pend_q, phv_drop_q;
  logic [3:0] act_addr_q;
  logic [FW-1:0] f_dout;
  logic [DW-1:0] f_data, hdr_seg;
  logic [UW-1:0] f_user;
  logic [KW-1:0] f_keep;
  logic f_last, f_push, f_pop, f_full, f_empty, emit_hdr, emit_body;

  axis_pkt_fifo #(.W(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .axis_clk(axis_clk),
    .aresetn(aresetn),
    .wr_en_i(f_push),
    .din_i({s_axis_tdata, s_axis_tuser, s_axis_tkeep, s_axis_tlast}),
    .rd_en_i(f_pop),
    .dout_o(f_dout),
    .full_o(f_full),
    .empty_o(f_empty)
  );

  assign {f_data, f_user, f_keep, f_last} = f_dout;
  assign s_axis_tready = !f_full;
  assign f_push = s_axis_tvalid & !f_full;
  assign f_pop = !f_empty && (state_q == HDR_RD || (state_q == EMIT_BODY && m_axis_tready));
  assign emit_hdr = state_q == EMIT_HDR;
  assign emit_body = state_q == EMIT_BODY && !f_empty;
  assign hdr_seg = hdr_q[HDR_W-1-DW*int'(seg_q) -: DW];
  assign m_axis_tvalid = emit_hdr | emit_body;
  assign m_axis_tdata = emit_hdr ? hdr_seg : emit_body ? f_data : '0;
  assign m_axis_tuser = emit_hdr ? user_q[seg_q] : emit_body ? f_user : '0;
  assign m_axis_tkeep = emit_hdr ? keep_q[seg_q] : emit_body ? f_keep : '0;
  assign m_axis_tlast = emit_hdr ? last_q[seg_q] : emit_body & f_last;
  assign act_addr = act_addr_q;
  assign phv_drop = phv_drop_q;

  always_comb begin
    hdr_patch = hdr_q;
    for (int i = 0; i < ACT_NUM; i++) hdr_patch = patch(hdr_patch, phv_q, act_data[16*(ACT_NUM-1-i) +: 16]);
  end

  always_ff @(posedge axis_clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
      seg_q <= '0;
      last_seg_q <= '0;
      hdr_q <= '0;
      keep_q <= '0;
      user_q <= '0;
      last_q <= '0;
      phv_q <= '0;
      phv_pend_q <= 1'b0;
      phv_drop_q <= 1'b0;
      act_addr_q <= '0;
    end else begin
      // Leaving PATCH frees the slot, so a PHV arriving that same cycle is taken, not dropped.
      if (phv_valid_in) begin
        if (phv_pend_q && state_q != PATCH) phv_drop_q <= 1'b1;
        else phv_q <= phv_in;
      end
      phv_pend_q <= phv_valid_in || (phv_pend_q && state_q != PATCH);
      case (state_q)
        IDLE: if (phv_pend_q && !f_empty) state_q <= HDR_RD;
        HDR_RD: if (!f_empty) begin
          hdr_q[HDR_W-1-DW*int'(seg_q) -: DW] <= f_data;
          keep_q[seg_q] <= f_keep;
          user_q[seg_q] <= f_user;
          last_q[seg_q] <= f_last;
          if (seg_q == '0) act_addr_q <= f_data[123:120];
          if (f_last || seg_q == SIW'(SEG_NUM-1)) begin
            last_seg_q <= seg_q;
            seg_q <= '0;
            state_q <= ACT;
          end else seg_q <= seg_q + 1'b1;
        end
        ACT: state_q <= PATCH;
        PATCH: begin
          hdr_q <= hdr_patch;
          state_q <= EMIT_HDR;
        end
        EMIT_HDR: if (m_axis_tready) begin
          if (seg_q == last_seg_q) begin
            seg_q <= '0;
            state_q <= last_q[seg_q] ? IDLE : EMIT_BODY;
          end else seg_q <= seg_q + 1'b1;
        end
        EMIT_BODY: if (m_axis_tready && !f_empty && f_last) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_phv_deparser.sv
// tb_phv_deparser: scoreboard bench for header patching, AXIS flow control, PHV drop and async reset.
module tb_phv_deparser;
  logic axis_clk = 1'b0;
  logic aresetn = 1'b1;
  logic [255:0] s_axis_tdata, m_axis_tdata;
  logic [127:0] s_axis_tuser, m_axis_tuser;
  logic [31:0] s_axis_tkeep, m_axis_tkeep;
  logic s_axis_tvalid, s_axis_tlast, s_axis_tready;
  logic m_axis_tvalid, m_axis_tlast, m_axis_tready;
  logic [1123:0] phv_in, phv;
  logic phv_valid_in, phv_drop;
  logic [3:0] act_addr;
  logic [159:0] act_data;
  logic [159:0] aram [16];

  typedef struct {
    logic [255:0] d;
    logic [127:0] u;
    logic [31:0] k;
    logic l;
  } beat_t;
  beat_t exp_q[$];
  logic [255:0] pd [16];
  logic [255:0] ed [16];
  logic [127:0] pu [16];
  logic [31:0] pk [16];
  int total = 0, bad = 0, nout = 0, n0, cnt;

  always #5 axis_clk = ~axis_clk;

  phv_deparser dut (
    .axis_clk(axis_clk), .aresetn(aresetn),
    .s_axis_tdata(s_axis_tdata), .s_axis_tuser(s_axis_tuser), .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .phv_in(phv_in), .phv_valid_in(phv_valid_in), .act_addr(act_addr), .act_data(act_data),
    .m_axis_tdata(m_axis_tdata), .m_axis_tuser(m_axis_tuser), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
    .phv_drop(phv_drop)
  );

  always @(posedge axis_clk) act_data <= aram[act_addr];

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge axis_clk)
    if (aresetn && m_axis_tvalid) begin
      if (exp_q.size() == 0) chk("extra_beat", 1, 0);
      else begin
        chk("tdata", m_axis_tdata, exp_q[0].d);
        if (m_axis_tready) begin
          chk("tuser", m_axis_tuser, exp_q[0].u);
          chk("tkeep", m_axis_tkeep, exp_q[0].k);
          chk("tlast", m_axis_tlast, exp_q[0].l);
          void'(exp_q.pop_front());
          nout++;
        end
      end
    end

  task automatic make_pkt(input int n, input logic [3:0] addr);
    for (int i = 0; i < n; i++) begin
      for (int w = 0; w < 8; w++) pd[i][32*w +: 32] = $urandom;
      for (int w = 0; w < 4; w++) pu[i][32*w +: 32] = $urandom;
      pk[i] = '1;
    end
    pd[0][123:120] = addr;
    for (int i = 0; i < n; i++) ed[i] = pd[i];
  endtask

  task automatic rand_phv();
    phv = '0;
    for (int w = 0; w < 35; w++) phv[32*w +: 32] = $urandom;
  endtask

  task automatic send_pkt(input int n);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata = pd[i];
      s_axis_tuser = pu[i];
      s_axis_tkeep = pk[i];
      s_axis_tlast = i == n - 1;
      b.d = ed[i];
      b.u = pu[i];
      b.k = pk[i];
      b.l = i == n - 1;
      exp_q.push_back(b);
      cnt = 0;
      @(negedge axis_clk);
      while (!s_axis_tready && cnt < 200) begin
        @(negedge axis_clk);
        cnt++;
      end
      if (cnt >= 200) chk("s_tready_timeout", 0, 1);
      @(posedge axis_clk);
      #1;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0;
  endtask

  task automatic pulse_phv();
    phv_in = phv;
    phv_valid_in = 1'b1;
    @(posedge axis_clk);
    #1;
    phv_valid_in = 1'b0;
  endtask

  task automatic drain(input string tag);
    int k = 0;
    while (exp_q.size() != 0 && k < 300) begin
      @(posedge axis_clk);
      #1;
      k++;
    end
    chk(tag, exp_q.size(), 0);
    repeat (3) @(posedge axis_clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; s_axis_tdata = '0; s_axis_tuser = '0; s_axis_tkeep = '0;
    m_axis_tready = 1'b1; phv_valid_in = 1'b0; phv_in = '0; phv = '0;
    for (int i = 0; i < 16; i++) aram[i] = '0;
    #2 aresetn = 1'b0;
    repeat (3) @(posedge axis_clk);
    #1;
    chk("rst_s_tready", s_axis_tready, 1);
    chk("rst_m_tvalid", m_axis_tvalid, 0);
    chk("rst_m_tdata", m_axis_tdata, 0);
    chk("rst_act_addr", act_addr, 0);
    chk("rst_phv_drop", phv_drop, 0);
    aresetn = 1'b1;
    @(posedge axis_clk);
    #1;
    // 1: 2B[0] into header byte 16, latency and one beat per cycle
    aram[1][159:144] = 16'h0411;
    make_pkt(4, 4'd1);
    ed[3][143:128] = 16'hBEEF;
    rand_phv();
    phv[356 +: 16] = 16'hBEEF;
    send_pkt(4);
    pulse_phv();
    cnt = 0;
    while (!m_axis_tvalid && cnt < 100) begin
      @(posedge axis_clk);
      #1;
      cnt++;
    end
    chk("t1_latency", cnt, 7);
    n0 = nout;
    repeat (4) @(posedge axis_clk);
    #1;
    chk("t1_rate", nout - n0, 4);
    drain("t1_drain");
    // 2: 6B[2] at offset 0, body beats pass through
    aram[2][111:96] = 16'h0035;
    make_pkt(6, 4'd2);
    rand_phv();
    phv[836 +: 48] = 48'h0A0B0C0D0E0F;
    ed[3][47:0] = 48'h0A0B0C0D0E0F;
    n0 = nout;
    send_pkt(6);
    pulse_phv();
    drain("t2_drain");
    chk("t2_beats", nout - n0, 6);
    // 3: short packet, patch lands outside the emitted segments
    aram[3][159:144] = 16'h0223;
    make_pkt(2, 4'd3);
    pk[1] = 32'h0000FFFF;
    rand_phv();
    n0 = nout;
    send_pkt(2);
    pulse_phv();
    drain("t3_drain");
    chk("t3_beats", nout - n0, 2);
    // 4: toggling tready, overlap (higher index wins), top-edge fit and out-of-range skip
    aram[4][63:48] = 16'h1F95;
    aram[4][47:32] = 16'h1FF1;
    aram[4][31:16] = 16'h1019;
    aram[4][15:0] = 16'h101B;
    make_pkt(8, 4'd4);
    rand_phv();
    phv[388 +: 16] = 16'h1234;
    phv[420 +: 16] = 16'hDEAD;
    phv[436 +: 16] = 16'hCAFE;
    phv[740 +: 48] = 48'h55AA55AA55AA;
    ed[0][255:240] = 16'h1234;
    ed[1][15:0] = 16'hCAFE;
    n0 = nout;
    send_pkt(8);
    pulse_phv();
    for (int k = 0; k < 300 && exp_q.size() != 0; k++) begin
      m_axis_tready = ~m_axis_tready;
      @(posedge axis_clk);
      #1;
    end
    m_axis_tready = 1'b1;
    drain("t4_drain");
    chk("t4_beats", nout - n0, 8);
    chk("t4_no_drop", phv_drop, 0);
    // 5: second PHV while one is pending is dropped, first one is used
    rand_phv();
    phv[356 +: 16] = 16'h1111;
    pulse_phv();
    rand_phv();
    phv[356 +: 16] = 16'h2222;
    pulse_phv();
    chk("t5_drop", phv_drop, 1);
    make_pkt(4, 4'd1);
    ed[3][143:128] = 16'h1111;
    send_pkt(4);
    drain("t5_drain");
    // 6: async reset in the body, then a clean packet
    make_pkt(8, 4'd1);
    rand_phv();
    phv[356 +: 16] = 16'h7777;
    ed[3][143:128] = 16'h7777;
    send_pkt(8);
    pulse_phv();
    n0 = nout;
    cnt = 0;
    while (nout < n0 + 5 && cnt < 100) begin
      @(posedge axis_clk);
      #1;
      cnt++;
    end
    chk("t6_in_body", nout - n0, 5);
    aresetn = 1'b0;
    #1;
    chk("t6_rst_tvalid", m_axis_tvalid, 0);
    chk("t6_rst_tready", s_axis_tready, 1);
    exp_q.delete();
    repeat (2) @(posedge axis_clk);
    #1;
    aresetn = 1'b1;
    chk("t6_drop_clr", phv_drop, 0);
    @(posedge axis_clk);
    #1;
    make_pkt(5, 4'd2);
    rand_phv();
    phv[836 +: 48] = 48'h112233445566;
    ed[3][47:0] = 48'h112233445566;
    n0 = nout;
    send_pkt(5);
    pulse_phv();
    drain("t6_drain");
    chk("t6_beats", nout - n0, 5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
